trig_phase_link_decoder: RTL and testbench

//  Receive-side decoder for the 160 MHz byte stream carrying trigger phase (4 bytes per 40 MHz frame).

---
 rtl/trig_phase_link_decoder.sv | 181 ++++++++++++++++++
 tb/tb_trig_phase_link_decoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_phase_link_decoder.sv
// Trigger-phase link decoder: aligns the 4-byte frame on the idle pattern and recovers trigger pulses and their phase.
// Latency one clk160 from the slot-3 byte to trig/status outputs; no backpressure (free-running byte stream in, pulses out).
module trig_phase_link_decoder #(
   parameter int unsigned LOCK_FRAMES = 4,
   parameter int unsigned UNLOCK_ERRS = 3,
   parameter logic [7:0]  IDLE_B0     = 8'h35,
   parameter logic [7:0]  IDLE_BN     = 8'h33
) (
   input  logic        clk160,
   input  logic        reset,
   input  logic [7:0]  rx_byte,
   input  logic        clear_counts,
   output logic        locked,
   output logic        frame_start,
   output logic        trig_valid,
   output logic [7:0]  trig_phase_out,
   output logic [31:0] trig_count,
   output logic [15:0] err_count
);

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam logic [7:0] LOCK_N   = 8'(LOCK_FRAMES);
   localparam logic [7:0] UNLOCK_N = 8'(UNLOCK_ERRS);

   state_t      state_q, state_d;
   logic [31:0] w_q, w_d;
   logic [1:0]  slot_q, slot_d;
   logic [7:0]  good_q, good_d;
   logic [7:0]  bad_q, bad_d;
   logic        frame_start_q, frame_start_d;
   logic        trig_valid_q, trig_valid_d;
   logic [7:0]  phase_q, phase_d;
   logic [31:0] trig_count_q, trig_count_d;
   logic [15:0] err_count_q, err_count_d;

   logic [31:0] frame;
   logic        is_idle;
   logic        is_trig;
   logic        eval;
   logic [7:0]  good_inc;
   logic [7:0]  bad_inc;
   logic [7:0]  rx_rev;

   // Slot 0 is the oldest byte of the candidate frame.
   assign frame    = {w_q[23:0], rx_byte};
   assign is_idle  = (frame[31:24] == IDLE_B0) && (frame[23:16] == IDLE_BN) &&
                     (frame[15:8] == IDLE_BN) && (frame[7:0] == IDLE_BN);
   assign is_trig  = (frame[31:8] == 24'h000000);
   assign eval     = (slot_q == 2'd3);
   assign good_inc = good_q + 8'd1;
   assign bad_inc  = bad_q + 8'd1;

   always_comb begin
      rx_rev = 8'h00;
      for (int i = 0; i < 8; i++) begin
         rx_rev[i] = rx_byte[7-i];
      end
   end

   always_comb begin
      state_d       = state_q;
      w_d           = {w_q[23:0], rx_byte};
      slot_d        = slot_q + 2'd1;
      good_d        = good_q;
      bad_d         = bad_q;
      frame_start_d = (state_q != ST_HUNT) && (slot_q == 2'd0);
      trig_valid_d  = 1'b0;
      phase_d       = phase_q;
      trig_count_d  = trig_count_q;
      err_count_d   = err_count_q;

      case (state_q)
         ST_HUNT: begin
            slot_d = 2'd0;
            if (is_idle) begin
               good_d = 8'd1;
               if (LOCK_N <= 8'd1) begin
                  state_d = ST_LOCKED;
                  bad_d   = 8'd0;
               end else begin
                  state_d = ST_VERIFY;
               end
            end
         end

         ST_VERIFY: begin
            if (eval) begin
               if (is_idle) begin
                  good_d = good_inc;
                  if (good_inc >= LOCK_N) begin
                     state_d = ST_LOCKED;
                     bad_d   = 8'd0;
                  end
               end else if (is_trig) begin
                  good_d = 8'd0;
               end else begin
                  state_d = ST_HUNT;
                  slot_d  = 2'd0;
                  good_d  = 8'd0;
               end
            end
         end

         ST_LOCKED: begin
            if (eval) begin
               if (is_idle) begin
                  bad_d = 8'd0;
               end else if (is_trig) begin
                  bad_d        = 8'd0;
                  trig_valid_d = 1'b1;
                  phase_d      = rx_rev;
                  trig_count_d = trig_count_q + 32'd1;
               end else begin
                  if (err_count_q != 16'hFFFF) begin
                     err_count_d = err_count_q + 16'd1;
                  end
                  bad_d = bad_inc;
                  if (bad_inc >= UNLOCK_N) begin
                     state_d = ST_HUNT;
                     slot_d  = 2'd0;
                     good_d  = 8'd0;
                     bad_d   = 8'd0;
                  end
               end
            end
         end

         default: begin
            state_d = ST_HUNT;
            slot_d  = 2'd0;
            good_d  = 8'd0;
            bad_d   = 8'd0;
         end
      endcase

      // A clear coinciding with an increment leaves the counter at zero.
      if (clear_counts) begin
         trig_count_d = 32'd0;
         err_count_d  = 16'd0;
      end
   end

   always_ff @(posedge clk160) begin
      if (reset) begin
         state_q       <= ST_HUNT;
         w_q           <= 32'd0;
         slot_q        <= 2'd0;
         good_q        <= 8'd0;
         bad_q         <= 8'd0;
         frame_start_q <= 1'b0;
         trig_valid_q  <= 1'b0;
         phase_q       <= 8'd0;
         trig_count_q  <= 32'd0;
         err_count_q   <= 16'd0;
      end else begin
         state_q       <= state_d;
         w_q           <= w_d;
         slot_q        <= slot_d;
         good_q        <= good_d;
         bad_q         <= bad_d;
         frame_start_q <= frame_start_d;
         trig_valid_q  <= trig_valid_d;
         phase_q       <= phase_d;
         trig_count_q  <= trig_count_d;
         err_count_q   <= err_count_d;
      end
   end

   assign locked         = (state_q == ST_LOCKED);
   assign frame_start    = frame_start_q;
   assign trig_valid     = trig_valid_q;
   assign trig_phase_out = phase_q;
   assign trig_count     = trig_count_q;
   assign err_count      = err_count_q;

endmodule

// File: tb/tb_trig_phase_link_decoder.sv
// Bench for trig_phase_link_decoder: directed byte streams, trigger scoreboard checked by a negedge monitor.
module tb_trig_phase_link_decoder;

   logic        clk160 = 1'b0;
   logic        reset;
   logic [7:0]  rx_byte;
   logic        clear_counts;
   logic        locked;
   logic        frame_start;
   logic        trig_valid;
   logic [7:0]  trig_phase_out;
   logic [31:0] trig_count;
   logic [15:0] err_count;

   typedef struct packed {
      logic [7:0]  phase;
      logic [31:0] count;
      logic [31:0] cyc;
   } trig_exp_t;

   trig_exp_t   exp_q[$];
   trig_exp_t   mon_e;
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] cyc     = 32'd0;
   logic [31:0] trig_model = 32'd0;

   trig_phase_link_decoder #(
      .LOCK_FRAMES (4),
      .UNLOCK_ERRS (3),
      .IDLE_B0     (8'h35),
      .IDLE_BN     (8'h33)
   ) dut (
      .clk160         (clk160),
      .reset          (reset),
      .rx_byte        (rx_byte),
      .clear_counts   (clear_counts),
      .locked         (locked),
      .frame_start    (frame_start),
      .trig_valid     (trig_valid),
      .trig_phase_out (trig_phase_out),
      .trig_count     (trig_count),
      .err_count      (err_count)
   );

   always #5 clk160 = ~clk160;
   always @(posedge clk160) cyc <= cyc + 32'd1;

   // Scoreboard monitor: every trig_valid pulse must match the oldest queued expectation.
   always @(negedge clk160) begin
      if (trig_valid) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_trig: trig_valid=1 phase=%02h count=%0d, required no pulse",
                     trig_phase_out, trig_count);
         end else begin
            mon_e = exp_q.pop_front();
            if (trig_phase_out !== mon_e.phase || trig_count !== mon_e.count || cyc !== mon_e.cyc) begin
               n_fail++;
               $display("FAIL trig_event: phase=%02h count=%0d cyc=%0d, required phase=%02h count=%0d cyc=%0d",
                        trig_phase_out, trig_count, cyc, mon_e.phase, mon_e.count, mon_e.cyc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_byte = b;
      @(posedge clk160);
      #1;
   endtask

   task automatic frame4(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
      send(b0);
      send(b1);
      send(b2);
      send(b3);
   endtask

   task automatic idle_frame();
      frame4(8'h35, 8'h33, 8'h33, 8'h33);
   endtask

   task automatic bad_frame();
      frame4(8'h35, 8'h33, 8'h34, 8'h33);
   endtask

   // Trigger frame sent while locked; phase_req is the hand-computed bit reversal.
   task automatic send_trig(input logic [7:0] b3, input logic [7:0] phase_req, input logic clr);
      trig_exp_t e;
      send(8'h00);
      send(8'h00);
      send(8'h00);
      clear_counts = clr;
      trig_model   = clr ? 32'd0 : trig_model + 32'd1;
      e.phase      = phase_req;
      e.count      = trig_model;
      e.cyc        = cyc + 32'd1;
      exp_q.push_back(e);
      send(b3);
      clear_counts = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_locked"},      {31'd0, locked},      32'd0);
      check({tag, "_frame_start"}, {31'd0, frame_start}, 32'd0);
      check({tag, "_trig_valid"},  {31'd0, trig_valid},  32'd0);
      check({tag, "_phase"},       {24'd0, trig_phase_out}, 32'd0);
      check({tag, "_trig_count"},  trig_count,           32'd0);
      check({tag, "_err_count"},   {16'd0, err_count},   32'd0);
   endtask

   initial begin
      reset        = 1'b1;
      rx_byte      = 8'h00;
      clear_counts = 1'b0;
      @(posedge clk160);
      @(posedge clk160);
      #1;
      check_all_zero("reset");
      reset = 1'b0;

      // Misaligned start then idles: lock after the 4th complete idle frame.
      send(8'h33);
      idle_frame();
      idle_frame();
      idle_frame();
      check("lock_after3", {31'd0, locked}, 32'd0);
      idle_frame();
      check("lock_after4", {31'd0, locked}, 32'd1);
      check("align_no_err", {16'd0, err_count}, 32'd0);

      // frame_start follows the 0x35 byte by one register stage.
      for (int f = 0; f < 2; f++) begin
         send(8'h35);
         check("fs_slot0", {31'd0, frame_start}, 32'd1);
         for (int k = 0; k < 3; k++) begin
            send(8'h33);
            check("fs_slotn", {31'd0, frame_start}, 32'd0);
         end
      end

      // Triggers while locked.
      send_trig(8'hC0, 8'h03, 1'b0);
      idle_frame();
      check("phase_held", {24'd0, trig_phase_out}, 32'h03);
      send_trig(8'h12, 8'h48, 1'b0);
      idle_frame();
      check("trig_count2", trig_count, 32'd2);

      // Bad frames separated by an idle do not unlock.
      bad_frame();
      bad_frame();
      idle_frame();
      bad_frame();
      bad_frame();
      check("bad_sep_locked", {31'd0, locked}, 32'd1);
      check("bad_sep_err", {16'd0, err_count}, 32'd4);
      idle_frame();

      // Three consecutive bad frames unlock.
      bad_frame();
      check("bad1_err", {16'd0, err_count}, 32'd5);
      check("bad1_locked", {31'd0, locked}, 32'd1);
      bad_frame();
      check("bad2_locked", {31'd0, locked}, 32'd1);
      bad_frame();
      check("bad3_err", {16'd0, err_count}, 32'd7);
      check("bad3_unlocked", {31'd0, locked}, 32'd0);

      // Relock; a trigger frame in VERIFY restarts the good count and emits nothing.
      idle_frame();
      frame4(8'h00, 8'h00, 8'h00, 8'hC0);
      idle_frame();
      idle_frame();
      idle_frame();
      check("verify_trig_restart", {31'd0, locked}, 32'd0);
      idle_frame();
      check("relock", {31'd0, locked}, 32'd1);
      check("relock_err", {16'd0, err_count}, 32'd7);
      check("relock_trig_count", trig_count, 32'd2);

      // Clear coincident with a trigger.
      send_trig(8'hC0, 8'h03, 1'b1);
      check("clr_err", {16'd0, err_count}, 32'd0);
      check("clr_locked", {31'd0, locked}, 32'd1);
      idle_frame();
      send_trig(8'h01, 8'h80, 1'b0);
      idle_frame();

      // Saturation of err_count.
      force dut.err_count_q = 16'hFFFE;
      #1;
      release dut.err_count_q;
      bad_frame();
      check("sat_ffff_a", {16'd0, err_count}, 32'h0000FFFF);
      bad_frame();
      check("sat_ffff_b", {16'd0, err_count}, 32'h0000FFFF);
      idle_frame();
      bad_frame();
      check("sat_ffff_c", {16'd0, err_count}, 32'h0000FFFF);
      check("sat_locked", {31'd0, locked}, 32'd1);
      idle_frame();

      // Reset in the middle of a trigger frame.
      send(8'h00);
      send(8'h00);
      reset = 1'b1;
      send(8'h00);
      reset = 1'b0;
      check_all_zero("midreset");
      trig_model = 32'd0;
      send(8'hC0);
      idle_frame();
      idle_frame();
      idle_frame();
      check("postreset_lock3", {31'd0, locked}, 32'd0);
      idle_frame();
      check("postreset_lock4", {31'd0, locked}, 32'd1);
      send_trig(8'hA0, 8'h05, 1'b0);
      idle_frame();
      idle_frame();

      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
